// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment scan driver.
// A synchronised rising edge of refresh_in advances the scan by one digit.
// Each digit switch is followed by an all-off blank interval.
// The digit shown is snapshotted at the strobe, so later input changes cannot tear it.
// Optional feature macro: SEG7_COLON_BLINK_EN gates the digit 2 dp with a 1 Hz phase.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refresh_in,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    localparam logic [7:0] CNT_LOAD = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
    localparam logic [3:0] AN_OFF   = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF   = SEG_ACTIVE_LOW;

    logic       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic       strobe_q, strobe_d;
    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] snap_nib_q, snap_nib_d;
    logic       snap_dp_q, snap_dp_d;
    logic       snap_lz_q, snap_lz_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] an_lit;
    logic [6:0] seg_lit;
    logic       dp_lit;
    logic       dp_gate;

    // Active-high glyph for a nibble; non-BCD values show a dash.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    endfunction

    // Two-flop synchroniser followed by a registered rising-edge detect.
    always_comb begin
        sync1_d  = refresh_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        strobe_d = sync2_q & ~sync3_q;
    end

`ifdef SEG7_COLON_BLINK_EN
    logic [8:0] scnt_q, scnt_d;
    logic       phase_q, phase_d;

    // Strobe counter 0..499; the blink phase flips on each wrap.
    always_comb begin
        scnt_d  = scnt_q;
        phase_d = phase_q;
        if (strobe_q) begin
            if (scnt_q == 9'd499) begin
                scnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                scnt_d = scnt_q + 9'd1;
            end
        end
    end

    // Blink phase register (starts lit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            scnt_q  <= scnt_d;
            phase_q <= phase_d;
        end
    end

    assign dp_gate = (idx_d != 2'd2) | phase_q;
`else
    assign dp_gate = 1'b1;
`endif

    // State register plus synchroniser, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            strobe_q     <= 1'b0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            snap_nib_q   <= '0;
            snap_dp_q    <= 1'b0;
            snap_lz_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            strobe_q     <= strobe_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            snap_nib_q   <= snap_nib_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: a strobe advances the digit and restarts the blank interval from any state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        snap_nib_d   = snap_nib_q;
        snap_dp_d    = snap_dp_q;
        snap_lz_d    = snap_lz_q;
        frame_done_d = 1'b0;
        if (strobe_q) begin
            idx_d        = (state_q == ST_IDLE) ? 2'd0 : idx_q + 2'd1;
            frame_done_d = (state_q != ST_IDLE) && (idx_q == 2'd3);
            state_d      = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            cnt_d        = CNT_LOAD;
            snap_nib_d   = digits[{idx_d, 2'b00} +: 4];
            snap_dp_d    = dp_mask[idx_d] & dp_gate;
            snap_lz_d    = lz_blank && (idx_d == 2'd3) && (snap_nib_d == 4'd0);
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == 8'd0) begin
                state_d = ST_SHOW;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    // Outputs: computed from the next state so the registered outputs line up with the state.
    always_comb begin
        an_lit  = '0;
        seg_lit = '0;
        dp_lit  = 1'b0;
        if (state_d == ST_SHOW) begin
            an_lit  = 4'b0001 << idx_d;
            seg_lit = snap_lz_d ? 7'h00 : glyph(snap_nib_d);
            dp_lit  = snap_dp_d;
        end
        an_d  = AN_ACTIVE_LOW  ? ~an_lit  : an_lit;
        seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (16-cycle blank with active-low outputs,
// and no blank with active-high outputs) checked every cycle against a strobe-level model.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        refresh_in = 1'b0;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_mask = 4'b0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: strobe-level view of the scan.
    int   edge_cnt = 0;
    int   q[$];
    bit   m_active = 0;
    int   m_idx = 0;
    int   m_last = 0;
    int   m_fd_edge = -1;
    logic [3:0] m_nib = 0;
    bit   m_dp = 0;
    bit   m_lz = 0;
    int   m_sc = 0;
    bit   m_phase = 1;

    bit   gen_en = 1;
    int   ref_cnt = 0;
    int   hmin = 2;
    int   hmax = 5;

    logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    seg7_scan_driver dut0 (
        .clk(clk), .rst(rst), .refresh_in(refresh_in), .digits(digits),
        .dp_mask(dp_mask), .lz_blank(lz_blank),
        .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
    );

    seg7_scan_driver #(.BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst(rst), .refresh_in(refresh_in), .digits(digits),
        .dp_mask(dp_mask), .lz_blank(lz_blank),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active  = 0;
        m_fd_edge = -1;
        m_sc      = 0;
        m_phase   = 1;
    endtask

    // Applies a strobe scheduled for this clock edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (q.size() > 0 && q[0] == edge_cnt) begin
            void'(q.pop_front());
            if (!m_active) begin
                m_active = 1;
                m_idx    = 0;
            end else begin
                if (m_idx == 3) m_fd_edge = edge_cnt;
                m_idx = (m_idx + 1) % 4;
            end
            m_last = edge_cnt;
            m_nib  = digits[m_idx*4 +: 4];
            m_dp   = dp_mask[m_idx];
`ifdef SEG7_COLON_BLINK_EN
            if (m_idx == 2) m_dp = m_dp & m_phase;
            m_sc++;
            if (m_sc == 500) begin
                m_sc    = 0;
                m_phase = ~m_phase;
            end
`endif
            m_lz = lz_blank && (m_idx == 3) && (m_nib == 4'd0);
        end
    endtask

    task automatic check_one(input string name, input int blank, input bit seg_lo, input bit an_lo,
                             input logic [3:0] an_g, input logic [6:0] seg_g, input logic dp_g,
                             input logic fd_g);
        bit         show;
        logic [3:0] an_l;
        logic [6:0] seg_l;
        logic       dp_l;
        show  = m_active && ((edge_cnt - m_last) >= blank);
        an_l  = show ? (4'b0001 << m_idx) : 4'b0000;
        seg_l = (show && !m_lz) ? glyph_tab[m_nib] : 7'h00;
        dp_l  = show && m_dp;
        check({name, "_an"},  {12'h0, an_g},  {12'h0, an_lo ? ~an_l : an_l});
        check({name, "_seg"}, {9'h0, seg_g},  {9'h0, seg_lo ? ~seg_l : seg_l});
        check({name, "_dp"},  {15'h0, dp_g},  {15'h0, seg_lo ? ~dp_l : dp_l});
        check({name, "_fd"},  {15'h0, fd_g},  {15'h0, m_fd_edge == edge_cnt});
    endtask

    task automatic check_outputs();
        check_one("b16", 16, 1'b1, 1'b1, an0, seg0, dp0, fd0);
        check_one("b0",  0,  1'b0, 1'b0, an1, seg1, dp1, fd1);
    endtask

    // One clock: model update at the edge, refresh generation after it, check at negedge.
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        model_edge();
        #1;
        if (!gen_en) begin
            refresh_in = 1'b0;
        end else if (ref_cnt == 0) begin
            refresh_in = ~refresh_in;
            if (refresh_in) q.push_back(edge_cnt + 4);
            ref_cnt = $urandom_range(hmax, hmin);
        end else begin
            ref_cnt--;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int waited;
        // Reset held with refresh toggling: outputs must stay inactive.
        repeat (20) step();
        gen_en = 0;
        repeat (6) step();
        rst    = 1'b0;
        gen_en = 1;

        // Scan order with a slow, regular refresh.
        hmin = 39;
        hmax = 39;
        repeat (800) step();

        // Leading-zero blank and non-BCD dash, then leading-zero blanking off.
        digits   = 16'h0F59;
        lz_blank = 1'b1;
        dp_mask  = 4'b0100;
        repeat (700) step();
        lz_blank = 1'b0;
        repeat (700) step();

        // Mid-scan reset while digit 2 is on, refresh low and no edge in flight.
        waited = 0;
        while (!(m_active && m_idx == 2 && (edge_cnt - m_last) >= 16 &&
                 refresh_in == 1'b0 && ref_cnt > 6 && q.size() == 0) && waited < 4000) begin
            step();
            waited++;
        end
        check("rst_wait_timeout", {15'h0, waited >= 4000}, 16'h0);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step();
        rst = 1'b0;
        repeat (400) step();

        // Randomised: short refresh phases (strobes inside blank), changing inputs.
        hmin = 0;
        hmax = 30;
        for (int i = 0; i < 15000; i++) begin
            step();
            if ($urandom_range(7) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(3) == 0) digits[15:12] = 4'h0;
            end
            if ($urandom_range(31) == 0) begin
                dp_mask  = 4'($urandom);
                lz_blank = 1'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
